lineattr_sched: RTL and testbench

//  Ping-pong scheduler for two 256x2 line attribute buffers (1 sync write port, 1 async read port each).

---
 rtl/lineattr_sched_pkg.sv | 23 ++
 rtl/lineattr_sched.sv | 159 +++++++++++++++
 tb/tb_lineattr_sched.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lineattr_sched_pkg.sv
// -----------------------------------------------------------------------------
// lineattr_sched_pkg
//   Shared definitions for the line attribute ping-pong scheduler:
//   scheduler state encoding, line width and a small helper that recognises
//   the final entry of a clear sweep.
// -----------------------------------------------------------------------------
package lineattr_sched_pkg;

    // Number of attribute entries in one scanline buffer.
    localparam int LINE_W = 256;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // True when the clear counter points at the last buffer entry, i.e. the
    // write issued this cycle completes the sweep.
    function automatic logic is_last_clear(input logic [7:0] cnt);
        return cnt == 8'(LINE_W - 1);
    endfunction

endpackage

// File: rtl/lineattr_sched.sv
// -----------------------------------------------------------------------------
// lineattr_sched
//   Ping-pong scheduler for two 256x2 line attribute buffers. The display
//   reads the front buffer while the background and sprite renderers fill the
//   back buffer. Each line_start swaps the buffers and auto-clears the new
//   back buffer before any renderer write is accepted.
//
// Parameters
//   CLEAR_VAL   attribute written to every entry during a clear sweep
//
// Ports
//   clk, reset_n         clock, asynchronous active-low reset
//   line_start           scanline start pulse: swap buffers, restart clear
//   bg_req/idx/data      background write request
//   bg_ack               background request accepted this cycle (comb)
//   spr_req/idx/data     sprite write request (data 2'b00 = transparent)
//   spr_ack              sprite request accepted this cycle (comb)
//   clr_busy             clear sweep in progress, renderers stalled
//   disp_idx             display read index
//   disp_data            registered front-buffer attribute at disp_idx
//   front                buffer currently displayed
//   wb_idx/data          registered write index/data shared by both buffers
//   wb_wren0/1           registered per-buffer write enables
//   rb_idx               read index to both buffers (= disp_idx)
//   rb_data0/1           asynchronous read data from buffer 0/1
// -----------------------------------------------------------------------------
module lineattr_sched
    import lineattr_sched_pkg::*;
#(
    parameter logic [1:0] CLEAR_VAL = 2'b00
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       line_start,
    input  logic       bg_req,
    input  logic [7:0] bg_idx,
    input  logic [1:0] bg_data,
    output logic       bg_ack,
    input  logic       spr_req,
    input  logic [7:0] spr_idx,
    input  logic [1:0] spr_data,
    output logic       spr_ack,
    output logic       clr_busy,
    input  logic [7:0] disp_idx,
    output logic [1:0] disp_data,
    output logic       front,
    output logic [7:0] wb_idx,
    output logic [1:0] wb_data,
    output logic       wb_wren0,
    output logic       wb_wren1,
    output logic [7:0] rb_idx,
    input  logic [1:0] rb_data0,
    input  logic [1:0] rb_data1
);

    state_t     state_q,     state_d;
    logic [7:0] clr_cnt_q,   clr_cnt_d;
    logic       front_q,     front_d;
    logic [7:0] wb_idx_q,    wb_idx_d;
    logic [1:0] wb_data_q,   wb_data_d;
    logic       wb_wren0_q,  wb_wren0_d;
    logic       wb_wren1_q,  wb_wren1_d;
    logic [1:0] disp_data_q, disp_data_d;
    logic       wr_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_CLEAR;
            clr_cnt_q   <= 8'd0;
            front_q     <= 1'b0;
            wb_idx_q    <= 8'd0;
            wb_data_q   <= 2'b00;
            wb_wren0_q  <= 1'b0;
            wb_wren1_q  <= 1'b0;
            disp_data_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            front_q     <= front_d;
            wb_idx_q    <= wb_idx_d;
            wb_data_q   <= wb_data_d;
            wb_wren0_q  <= wb_wren0_d;
            wb_wren1_q  <= wb_wren1_d;
            disp_data_q <= disp_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        front_d   = front_q;
        wb_idx_d  = wb_idx_q;
        wb_data_d = wb_data_q;
        wr_en     = 1'b0;
        bg_ack    = 1'b0;
        spr_ack   = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                // One clear write per cycle; renderers stay un-acked.
                wr_en     = 1'b1;
                wb_idx_d  = clr_cnt_q;
                wb_data_d = CLEAR_VAL;
                clr_cnt_d = clr_cnt_q + 8'd1;
                if (is_last_clear(clr_cnt_q)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Background has fixed priority; a losing sprite simply holds
                // its request until it is granted.
                if (bg_req) begin
                    bg_ack    = 1'b1;
                    wr_en     = 1'b1;
                    wb_idx_d  = bg_idx;
                    wb_data_d = bg_data;
                end else if (spr_req) begin
                    spr_ack = 1'b1;
                    // Transparent sprite pixels are consumed without a write.
                    if (spr_data != 2'b00) begin
                        wr_en     = 1'b1;
                        wb_idx_d  = spr_idx;
                        wb_data_d = spr_data;
                    end
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase

        // line_start overrides everything: swap and (re)start a full clear.
        // Any write decided above still targets the pre-swap back buffer.
        if (line_start) begin
            front_d   = ~front_q;
            clr_cnt_d = 8'd0;
            state_d   = ST_CLEAR;
        end

        // The back buffer is ~front at grant time, so the enables are
        // mutually exclusive by construction.
        wb_wren0_d = wr_en &  front_q;
        wb_wren1_d = wr_en & ~front_q;

        // Select with the post-edge front so a swap and the read that
        // follows it take effect on the same edge.
        disp_data_d = front_d ? rb_data1 : rb_data0;
    end

    assign clr_busy  = (state_q == ST_CLEAR);
    assign front     = front_q;
    assign wb_idx    = wb_idx_q;
    assign wb_data   = wb_data_q;
    assign wb_wren0  = wb_wren0_q;
    assign wb_wren1  = wb_wren1_q;
    assign disp_data = disp_data_q;
    assign rb_idx    = disp_idx;

endmodule

// File: tb/tb_lineattr_sched.sv
// -----------------------------------------------------------------------------
// tb_lineattr_sched
//   Bench for lineattr_sched. Two behavioural buffers are attached to the
//   write/read ports; a reference model tracks front, remaining clear entries,
//   expected grants/writes and the expected buffer contents.
// -----------------------------------------------------------------------------
module tb_lineattr_sched;

    localparam logic [1:0] CV = 2'b00;

    typedef struct packed {
        logic       ls;
        logic       br;
        logic [7:0] bi;
        logic [1:0] bd;
        logic       sr;
        logic [7:0] si;
        logic [1:0] sd;
        logic [7:0] di;
    } in_t;

    typedef struct packed {
        logic       bga;
        logic       spa;
        logic       w0;
        logic       w1;
        logic [7:0] idx;
        logic [1:0] data;
        logic [1:0] disp;
        logic       front;
    } obs_t;

    typedef struct packed {
        in_t        s;
        logic       ebga;
        logic       espa;
        logic       ew0;
        logic       ew1;
        logic [7:0] eidx;
        logic [1:0] edata;
    } vec_t;

    logic       clk;
    logic       reset_n;
    logic       line_start;
    logic       bg_req, spr_req;
    logic [7:0] bg_idx, spr_idx, disp_idx;
    logic [1:0] bg_data, spr_data;
    logic       bg_ack, spr_ack, clr_busy, front;
    logic [1:0] disp_data;
    logic [7:0] wb_idx, rb_idx;
    logic [1:0] wb_data, rb_data0, rb_data1;
    logic       wb_wren0, wb_wren1;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         m_clear_left;
    logic       m_front;
    logic [1:0] m_ref [2][256];
    logic       m_pend_en;
    logic       m_pend_buf;
    logic [7:0] m_pend_idx;
    logic [1:0] m_pend_data;

    // Physical buffer models
    logic [1:0] mem0 [256];
    logic [1:0] mem1 [256];

    lineattr_sched dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .line_start (line_start),
        .bg_req     (bg_req),
        .bg_idx     (bg_idx),
        .bg_data    (bg_data),
        .bg_ack     (bg_ack),
        .spr_req    (spr_req),
        .spr_idx    (spr_idx),
        .spr_data   (spr_data),
        .spr_ack    (spr_ack),
        .clr_busy   (clr_busy),
        .disp_idx   (disp_idx),
        .disp_data  (disp_data),
        .front      (front),
        .wb_idx     (wb_idx),
        .wb_data    (wb_data),
        .wb_wren0   (wb_wren0),
        .wb_wren1   (wb_wren1),
        .rb_idx     (rb_idx),
        .rb_data0   (rb_data0),
        .rb_data1   (rb_data1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 256; i++) begin
                mem0[i] <= 2'b11;
                mem1[i] <= 2'b11;
            end
        end else begin
            if (wb_wren0) mem0[wb_idx] <= wb_data;
            if (wb_wren1) mem1[wb_idx] <= wb_data;
        end
    end
    assign rb_data0 = mem0[rb_idx];
    assign rb_data1 = mem1[rb_idx];

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic in_t idle(input logic [7:0] di);
        in_t s;
        s = '0;
        s.di = di;
        return s;
    endfunction

    function automatic vec_t mk(input logic br, input logic [7:0] bi, input logic [1:0] bd,
                                input logic sr, input logic [7:0] si, input logic [1:0] sd,
                                input logic ebga, input logic espa, input logic ew0, input logic ew1,
                                input logic [7:0] eidx, input logic [1:0] edata);
        vec_t v;
        v.s       = '0;
        v.s.br    = br;
        v.s.bi    = bi;
        v.s.bd    = bd;
        v.s.sr    = sr;
        v.s.si    = si;
        v.s.sd    = sd;
        v.ebga    = ebga;
        v.espa    = espa;
        v.ew0     = ew0;
        v.ew1     = ew1;
        v.eidx    = eidx;
        v.edata   = edata;
        return v;
    endfunction

    // One clock: drive, check combinational outputs, advance, check registered
    // outputs, then advance the reference model.
    task automatic cycle(input in_t s, output obs_t o);
        logic       busy, ebga, espa, wen, wbuf, fnext;
        logic [7:0] widx;
        logic [1:0] wdata, edisp;

        line_start = s.ls;
        bg_req     = s.br;
        bg_idx     = s.bi;
        bg_data    = s.bd;
        spr_req    = s.sr;
        spr_idx    = s.si;
        spr_data   = s.sd;
        disp_idx   = s.di;
        #1;
        busy = (m_clear_left > 0);
        ebga = !busy && s.br;
        espa = !busy && s.sr && !s.br;
        o.bga = bg_ack;
        o.spa = spr_ack;
        chk("clr_busy", clr_busy, busy);
        chk("bg_ack", bg_ack, ebga);
        chk("spr_ack", spr_ack, espa);

        wen   = 1'b0;
        wbuf  = !m_front;
        widx  = 8'd0;
        wdata = 2'd0;
        if (busy) begin
            wen = 1'b1; widx = 8'(256 - m_clear_left); wdata = CV;
        end else if (ebga) begin
            wen = 1'b1; widx = s.bi; wdata = s.bd;
        end else if (espa && s.sd != 2'b00) begin
            wen = 1'b1; widx = s.si; wdata = s.sd;
        end
        fnext = s.ls ? !m_front : m_front;
        // The read at this edge sees contents before the pending write lands.
        edisp = m_ref[fnext][s.di];
        if (m_pend_en) m_ref[m_pend_buf][m_pend_idx] = m_pend_data;
        m_pend_en   = wen;
        m_pend_buf  = wbuf;
        m_pend_idx  = widx;
        m_pend_data = wdata;

        @(posedge clk);
        #1;
        o.w0    = wb_wren0;
        o.w1    = wb_wren1;
        o.idx   = wb_idx;
        o.data  = wb_data;
        o.disp  = disp_data;
        o.front = front;
        chk("wb_wren0", wb_wren0, wen && !wbuf);
        chk("wb_wren1", wb_wren1, wen && wbuf);
        if (wen) begin
            chk("wb_idx", wb_idx, widx);
            chk("wb_data", wb_data, wdata);
        end
        chk("front", front, fnext);
        chk("disp_data", disp_data, edisp);
        m_front      = fnext;
        m_clear_left = s.ls ? 256 : (busy ? m_clear_left - 1 : 0);
    endtask

    vec_t       tbl [6];
    obs_t       o;
    in_t        s;
    logic [1:0] pat [256];
    logic       f0;
    int         cnt;

    initial begin
        tbl[0] = mk(1, 8'h10, 2'd2, 0, 8'h00, 2'd0, 1, 0, 0, 1, 8'h10, 2'd2);
        tbl[1] = mk(1, 8'h20, 2'd1, 1, 8'h30, 2'd3, 1, 0, 0, 1, 8'h20, 2'd1);
        tbl[2] = mk(0, 8'h00, 2'd0, 1, 8'h30, 2'd3, 0, 1, 0, 1, 8'h30, 2'd3);
        tbl[3] = mk(0, 8'h00, 2'd0, 1, 8'h40, 2'd0, 0, 1, 0, 0, 8'h00, 2'd0);
        tbl[4] = mk(0, 8'h00, 2'd0, 1, 8'hFF, 2'd3, 0, 1, 0, 1, 8'hFF, 2'd3);
        tbl[5] = mk(0, 8'h00, 2'd0, 0, 8'h00, 2'd0, 0, 0, 0, 0, 8'h00, 2'd0);

        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 256; i++) m_ref[b][i] = 2'b11;
        m_front      = 1'b0;
        m_clear_left = 256;
        m_pend_en    = 1'b0;
        m_pend_buf   = 1'b0;
        m_pend_idx   = 8'd0;
        m_pend_data  = 2'd0;

        // Reset state, with requests asserted to show they are not acked.
        reset_n    = 1'b0;
        line_start = 1'b0;
        bg_req     = 1'b1;
        bg_idx     = 8'h55;
        bg_data    = 2'd3;
        spr_req    = 1'b1;
        spr_idx    = 8'h66;
        spr_data   = 2'd2;
        disp_idx   = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_front", front, 1'b0);
        chk("rst_clr_busy", clr_busy, 1'b1);
        chk("rst_wren0", wb_wren0, 1'b0);
        chk("rst_wren1", wb_wren1, 1'b0);
        chk("rst_wb_idx", wb_idx, 8'd0);
        chk("rst_wb_data", wb_data, 2'd0);
        chk("rst_disp_data", disp_data, 2'd0);
        chk("rst_bg_ack", bg_ack, 1'b0);
        chk("rst_spr_ack", spr_ack, 1'b0);
        reset_n = 1'b1;

        // Initial clear of buffer 1: 256 writes with idx 0..255.
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            s = idle(8'(i));
            s.br = 1'b1;
            cycle(s, o);
            if (o.w1 && !o.w0 && o.idx == 8'(i) && o.data == CV) cnt++;
        end
        chk("init_clear_writes", cnt, 256);
        #1;
        chk("init_clear_done", clr_busy, 1'b0);
        chk("init_front", front, 1'b0);

        // Directed grant table.
        for (int i = 0; i < 6; i++) begin
            cycle(tbl[i].s, o);
            chk($sformatf("tbl%0d_bg_ack", i), o.bga, tbl[i].ebga);
            chk($sformatf("tbl%0d_spr_ack", i), o.spa, tbl[i].espa);
            chk($sformatf("tbl%0d_wren0", i), o.w0, tbl[i].ew0);
            chk($sformatf("tbl%0d_wren1", i), o.w1, tbl[i].ew1);
            if (tbl[i].ew0 || tbl[i].ew1) begin
                chk($sformatf("tbl%0d_idx", i), o.idx, tbl[i].eidx);
                chk($sformatf("tbl%0d_data", i), o.data, tbl[i].edata);
            end
        end

        // line_start aborting a clear at clr_cnt=100.
        f0 = m_front;
        s = idle(8'd0);
        s.ls = 1'b1;
        cycle(s, o);
        for (int i = 0; i < 100; i++) cycle(idle(8'd0), o);
        cycle(s, o);
        chk("abort_inflight_idx", o.idx, 8'd100);
        chk("abort_front", o.front, f0);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            cycle(idle(8'd0), o);
            if ((f0 ? o.w0 : o.w1) && !(f0 ? o.w1 : o.w0) && o.idx == 8'(i)) cnt++;
        end
        chk("restart_clear_writes", cnt, 256);
        #1;
        chk("restart_clear_done", clr_busy, 1'b0);

        // Fill back buffer with a pattern, swap, sweep the display.
        for (int i = 0; i < 256; i++) begin
            pat[i] = 2'($urandom_range(0, 3));
            s = idle(8'd0);
            s.br = 1'b1;
            s.bi = 8'(i);
            s.bd = pat[i];
            cycle(s, o);
        end
        s = idle(8'd0);
        s.ls = 1'b1;
        cycle(s, o);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            cycle(idle(8'(i)), o);
            if (o.disp == pat[i]) cnt++;
        end
        chk("disp_sweep_matches", cnt, 256);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            s.ls = ($urandom_range(0, 199) == 0);
            s.br = $urandom_range(0, 1) == 1;
            s.bi = 8'($urandom);
            s.bd = 2'($urandom);
            s.sr = $urandom_range(0, 1) == 1;
            s.si = 8'($urandom);
            s.sd = 2'($urandom);
            s.di = 8'($urandom);
            cycle(s, o);
            chk("wren_exclusive", o.w0 & o.w1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
